// File: rtl/mbox_pkg.sv
// mbox_pkg: shared state encoding and width constants for the MBOX request sequencer.
package mbox_pkg;
  localparam int ADR_W = 23;
  localparam int DATA_W = 36;
  localparam int CLR_W = 3;
  localparam int TIMEOUT = 64;
  typedef enum logic [1:0] {IDLE, MEM, RESP, SWEEP} state_t;
endpackage

// File: rtl/mbox_sweep_ctr.sv
// mbox_sweep_ctr: sweep-pending flag and wrapping cache line counter stepped by the sequencer.
module mbox_sweep_ctr #(
  parameter int CLR_W = mbox_pkg::CLR_W
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             start,
  input  logic             adv,
  output logic             pending,
  output logic [CLR_W-1:0] idx,
  output logic             done
);
  assign done = &idx;
  // A start arriving on the final line is dropped: the sweep in flight already covers it.
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      pending <= 1'b0;
      idx     <= '0;
    end else begin
      pending <= (adv && done) ? 1'b0 : (pending || start);
      if (adv) idx <= idx + CLR_W'(1);
    end
endmodule

// File: rtl/mbox_req_seq.sv
// mbox_req_seq: arbitrates the MBOX memory port between EBOX requests and the cache-clear sweep.
// Optional MBOX_TIMEOUT_EN: abandon a memory cycle with an NXM strobe after TIMEOUT cycles.
module mbox_req_seq
  import mbox_pkg::*;
(
  input  logic              clk,
  input  logic              resetN,
  input  logic              eboxReq,
  input  logic              eboxRead,
  input  logic              eboxWrite,
  input  logic              eboxPSE,
  input  logic [ADR_W-1:0]  eboxVMA,
  input  logic [DATA_W-1:0] cacheDataWrite,
  output logic [DATA_W-1:0] cacheDataRead,
  output logic              mboxRespIn,
  input  logic              sweepStart,
  output logic              sweepBusy,
  output logic [CLR_W-1:0]  cacheClearer,
  output logic              clrWr,
  output logic              memReq,
  output logic              memWrite,
  output logic              memLock,
  output logic [ADR_W-1:0]  memAdr,
  output logic [DATA_W-1:0] memWData,
  input  logic              memAck,
  input  logic [DATA_W-1:0] memRData,
  output logic              nxmErr
);
  state_t state, nxt;
  logic wr_q, lock_q, pending, done, accept, tmo;
  assign accept = eboxReq && (state == IDLE || state == SWEEP);
  mbox_sweep_ctr #(.CLR_W(CLR_W)) u_sweep (
    .clk    (clk),
    .resetN (resetN),
    .start  (sweepStart),
    .adv    (state == SWEEP),
    .pending(pending),
    .idx    (cacheClearer),
    .done   (done)
  );
`ifdef MBOX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmr;
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) tmr <= '0;
    else tmr <= (state == MEM) ? tmr + TW'(1) : '0;
  assign tmo = (state == MEM) && !memAck && (tmr == TW'(TIMEOUT - 1));
`else
  assign tmo = 1'b0;
`endif
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) state <= IDLE;
    else state <= nxt;
  // EBOX wins over the sweep; a preempted sweep resumes on the line after the one just cleared.
  always_comb
    nxt = accept ? ((eboxRead || eboxWrite) ? MEM : RESP)
        : (state == IDLE) ? (pending ? SWEEP : IDLE)
        : (state == MEM) ? ((memAck || tmo) ? RESP : MEM)
        : (state == RESP) ? IDLE
        : (done ? IDLE : SWEEP);
  always_comb begin
    memReq     = state == MEM;
    memWrite   = memReq && wr_q;
    memLock    = memReq && lock_q;
    mboxRespIn = state == RESP;
    clrWr      = state == SWEEP;
    sweepBusy  = pending || clrWr;
    nxmErr     = tmo;
  end
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      memAdr        <= '0;
      memWData      <= '0;
      wr_q          <= 1'b0;
      lock_q        <= 1'b0;
      cacheDataRead <= '0;
    end else begin
      if (accept) begin
        memAdr   <= eboxVMA;
        memWData <= cacheDataWrite;
        wr_q     <= eboxWrite && !eboxRead;
        lock_q   <= eboxPSE;
      end
      if (accept && !eboxRead && !eboxWrite) cacheDataRead <= '0;
      else if (state == MEM && (memAck || tmo)) cacheDataRead <= (memAck && !wr_q) ? memRData : '0;
    end
endmodule

// File: tb/tb_mbox_req_seq.sv
// tb_mbox_req_seq: directed stimulus with an ordered scoreboard of responses and clear-line pulses.
module tb_mbox_req_seq;
  import mbox_pkg::*;
  logic clk = 0, resetN = 0;
  logic eboxReq = 0, eboxRead = 0, eboxWrite = 0, eboxPSE = 0, sweepStart = 0, memAck = 0;
  logic [ADR_W-1:0] eboxVMA = '0, memAdr;
  logic [DATA_W-1:0] cacheDataWrite = '0, memRData = '0, cacheDataRead, memWData;
  logic [CLR_W-1:0] cacheClearer;
  logic mboxRespIn, sweepBusy, clrWr, memReq, memWrite, memLock, nxmErr;
  int pass = 0, total = 0;
  typedef struct {bit kind; logic [DATA_W-1:0] val;} ev_t;
  ev_t sb[$];

  always #5 clk = ~clk;

  mbox_req_seq dut (
    .clk(clk), .resetN(resetN), .eboxReq(eboxReq), .eboxRead(eboxRead), .eboxWrite(eboxWrite),
    .eboxPSE(eboxPSE), .eboxVMA(eboxVMA), .cacheDataWrite(cacheDataWrite),
    .cacheDataRead(cacheDataRead), .mboxRespIn(mboxRespIn), .sweepStart(sweepStart),
    .sweepBusy(sweepBusy), .cacheClearer(cacheClearer), .clrWr(clrWr), .memReq(memReq),
    .memWrite(memWrite), .memLock(memLock), .memAdr(memAdr), .memWData(memWData),
    .memAck(memAck), .memRData(memRData), .nxmErr(nxmErr)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit k, input logic [DATA_W-1:0] v);
    sb.push_back('{kind: k, val: v});
  endtask

  task automatic req(input bit rd, input bit wr, input bit pse, input logic [ADR_W-1:0] vma,
                     input logic [DATA_W-1:0] wd);
    eboxReq = 1; eboxRead = rd; eboxWrite = wr; eboxPSE = pse; eboxVMA = vma; cacheDataWrite = wd;
    tick;
    eboxReq = 0; eboxRead = 0; eboxWrite = 0; eboxPSE = 0;
  endtask

  task automatic ack(input logic [DATA_W-1:0] d);
    memAck = 1; memRData = d;
    tick;
    memAck = 0; memRData = '0;
  endtask

  // Responses and clear pulses must appear in exactly the pushed order.
  always @(negedge clk) begin
    ev_t e;
    if (resetN && (mboxRespIn || clrWr)) begin
      if (sb.size() == 0) chk("unexpected_event", {mboxRespIn, clrWr}, 0);
      else begin
        e = sb.pop_front();
        chk("event_kind", clrWr, e.kind);
        chk(e.kind ? "clr_idx" : "resp_data", e.kind ? cacheClearer : cacheDataRead, e.val);
      end
    end
  end

  initial begin
    #12;
    chk("reset_outs", {memReq, memWrite, memLock, mboxRespIn, clrWr, sweepBusy, nxmErr}, 0);
    chk("reset_clr", cacheClearer, 0);
    chk("reset_rdata", cacheDataRead, 0);
    resetN = 1;
    tick;
    // read with memAck in the third MEM cycle
    push(0, 36'o123456701234);
    req(1, 0, 0, 23'o1234, '0);
    chk("rd_memreq_c1", memReq, 1);
    chk("rd_adr", memAdr, 23'o1234);
    chk("rd_memwrite", memWrite, 0);
    tick;
    chk("rd_memreq_c2", memReq, 1);
    tick;
    chk("rd_memreq_c3", memReq, 1);
    ack(36'o123456701234);
    chk("rd_resp", mboxRespIn, 1);
    chk("rd_memreq_off", memReq, 0);
    tick;
    chk("rd_resp_1cyc", mboxRespIn, 0);
    chk("rd_data_hold", cacheDataRead, 36'o123456701234);
    // write with PSE, immediate ack
    push(0, '0);
    req(0, 1, 1, 23'o7070, 36'o777777000000);
    chk("wr_memwrite", memWrite, 1);
    chk("wr_memlock", memLock, 1);
    chk("wr_wdata", memWData, 36'o777777000000);
    chk("wr_adr", memAdr, 23'o7070);
    ack(36'o555);
    chk("wr_resp_lat", mboxRespIn, 1);
    chk("wr_lock_off", memLock, 0);
    tick;
    // read+write acts as read; neither gives an immediate zero response
    push(0, 36'o42);
    req(1, 1, 0, 23'o5, 36'o7);
    chk("rw_memwrite", memWrite, 0);
    ack(36'o42);
    tick;
    push(0, '0);
    req(0, 0, 0, '0, '0);
    chk("noop_resp", mboxRespIn, 1);
    chk("noop_memreq", memReq, 0);
    tick;
`ifdef MBOX_TIMEOUT_EN
    push(0, '0);
    req(1, 0, 0, 23'o77, '0);
    for (int i = 1; i <= 64; i++) begin
      chk("nxm_pulse", nxmErr, (i == 64) ? 1 : 0);
      tick;
    end
    chk("nxm_memreq_off", memReq, 0);
    chk("nxm_resp", mboxRespIn, 1);
    memAck = 1;
    tick;
    memAck = 0;
    tick;
    chk("nxm_late_ack", mboxRespIn, 0);
`else
    push(0, 36'o11);
    req(1, 0, 0, 23'o77, '0);
    repeat (80) tick;
    chk("wait_memreq", memReq, 1);
    chk("wait_nxm", nxmErr, 0);
    ack(36'o11);
    tick;
`endif
    // full sweep
    for (int i = 0; i < 8; i++) push(1, i);
    sweepStart = 1;
    tick;
    sweepStart = 0;
    chk("sw_busy_pend", sweepBusy, 1);
    repeat (8) tick;
    chk("sw_last_idx", cacheClearer, 7);
    chk("sw_last_busy", sweepBusy, 1);
    tick;
    chk("sw_done_busy", sweepBusy, 0);
    chk("sw_done_clrwr", clrWr, 0);
    chk("sw_wrap", cacheClearer, 0);
    // preemption at line 3
    for (int i = 0; i < 4; i++) push(1, i);
    push(0, 36'o1);
    for (int i = 4; i < 8; i++) push(1, i);
    sweepStart = 1;
    tick;
    sweepStart = 0;
    repeat (4) tick;
    chk("pre_idx3", cacheClearer, 3);
    req(1, 0, 0, 23'o100, '0);
    chk("pre_memreq", memReq, 1);
    chk("pre_kept_idx", cacheClearer, 4);
    ack(36'o1);
    tick;
    chk("pre_idle_busy", sweepBusy, 1);
    chk("pre_idle_clrwr", clrWr, 0);
    repeat (5) tick;
    chk("pre_done_busy", sweepBusy, 0);
    chk("pre_wrap", cacheClearer, 0);
    // simultaneous request and sweepStart
    push(0, 36'o2);
    for (int i = 0; i < 8; i++) push(1, i);
    sweepStart = 1;
    req(1, 0, 0, 23'o200, '0);
    sweepStart = 0;
    chk("col_memreq", memReq, 1);
    chk("col_busy", sweepBusy, 1);
    ack(36'o2);
    tick;
    repeat (9) tick;
    chk("col_done_busy", sweepBusy, 0);
    // reset in the middle of a memory cycle
    req(1, 0, 0, 23'o3, '0);
    chk("rst_memreq_pre", memReq, 1);
    #2 resetN = 0;
    #1;
    chk("rst_outs", {memReq, memWrite, memLock, mboxRespIn, clrWr, sweepBusy, nxmErr}, 0);
    chk("rst_adr", memAdr, 0);
    memAck = 1;
    tick;
    tick;
    memAck = 0;
    #2 resetN = 1;
    tick;
    tick;
    chk("rst_no_resp", mboxRespIn, 0);
    chk("rst_idle", memReq, 0);
    repeat (3) tick;
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
